back_end: RTL and testbench

Drain stage on the coprocessor output side, running alongside the input-side controller. After `start`, it pops a programmed number of result words from the accelerator's output FIFO. It writes them to consecutive addresses of the output buffer memory from a base address, then raises `done` and holds it until `start` is released. It is the block that completes a memory-mapped transfer.

---
 rtl/copr_mm_pkg.sv | 21 ++
 rtl/back_end.sv | 110 +++++++++++
 tb/tb_back_end.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/copr_mm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : copr_mm_pkg
// Purpose  : Shared definitions for the coprocessor memory-mapped front/back
//            ends: default widths and the drain-stage state encoding.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package copr_mm_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WORK  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/back_end.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : back_end
// Purpose  : Output drain stage. Pops a programmed number of words from a
//            first-word-fall-through FIFO and writes them to consecutive
//            output-buffer addresses, then holds done until start drops.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module back_end
  import copr_mm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic              start,
  input  logic [ADDR_W:0]   size,
  input  logic [ADDR_W-1:0] base,
  input  logic              empty,
  input  logic [DATA_W-1:0] dout,
  output logic              rd,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done
);

  // A full address space is the most that can be written without overwriting.
  localparam logic [ADDR_W:0] MAX_SIZE = {1'b1, {ADDR_W{1'b0}}};

  state_t            state;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   size_clamped;

  // Limit the requested word count to one full pass of the address space.
  always_comb begin
    size_clamped = (size > MAX_SIZE) ? MAX_SIZE : size;
  end

  // Status and pop strobe decode directly from the state register.
  always_comb begin
    rd   = (state == ST_WORK) && !empty;
    busy = (state == ST_WORK) || (state == ST_FLUSH);
    done = (state == ST_DONE);
  end

  // Transfer FSM with word/address counters and registered memory port.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state     <= ST_IDLE;
      remaining <= '0;
      addr      <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_din   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (start) begin
            remaining <= size_clamped;
            addr      <= base;
            state     <= (size_clamped != '0) ? ST_WORK : ST_DONE;
          end
        end
        ST_WORK: begin
          if (!empty) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_din   <= dout;
            addr      <= addr + ADDR_W'(1);
            remaining <= remaining - (ADDR_W+1)'(1);
            if (remaining == (ADDR_W+1)'(1)) begin
              state <= ST_FLUSH;
            end
          end else begin
            // Stall: drop the strobes, keep address/data on the port.
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end
        end
        ST_FLUSH: begin
          // The final write occupies the port during this cycle.
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (!start) begin
            state <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_back_end.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_back_end
// Purpose  : Self-checking bench for back_end. A software FIFO feeds the
//            DUT; expected writes and done timing follow from the pop
//            sequence observed by a cycle-level transfer model.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_back_end;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int FIFO_DEPTH = 16384;

  logic          aclk = 1'b0;
  logic          areset;
  logic          start;
  logic [AW:0]   size;
  logic [AW-1:0] base;
  logic          stall;
  logic          empty;
  logic [DW-1:0] dout;
  logic          rd;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          busy;
  logic          done;

  logic [DW-1:0] fifo_mem [0:FIFO_DEPTH-1];
  int head = 0;
  int tail = 0;

  int checks = 0;
  int passed = 0;

  back_end #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .aclk     (aclk),
    .areset   (areset),
    .start    (start),
    .size     (size),
    .base     (base),
    .empty    (empty),
    .dout     (dout),
    .rd       (rd),
    .mem_en   (mem_en),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_din  (mem_din),
    .busy     (busy),
    .done     (done)
  );

  always #5 aclk = ~aclk;

  // First-word-fall-through FIFO model
  assign empty = stall || (head == tail);
  assign dout  = fifo_mem[head % FIFO_DEPTH];

  always @(posedge aclk) begin
    if (rd && !empty) head <= head + 1;
  end

  task automatic preload(input int k);
    for (int i = 0; i < k; i++) begin
      fifo_mem[tail % FIFO_DEPTH] = $urandom;
      tail++;
    end
  endtask

  // One transfer: stall_mode 0=never, 1=random, 2=cycles 2..4.
  // toggle scrambles start/size/base while words remain.
  // abort_after>0 pulses reset once that many writes have been observed.
  task automatic run_transfer(input logic [AW:0] sz, input logic [AW-1:0] bs,
                              input int stall_mode, input bit toggle,
                              input int abort_after, input string tag);
    int n, pops, writes, c, done_cycle, bound, h0;
    bit prev_pop, exp_done, exp_pop;
    logic [AW-1:0] exp_addr;
    n = (int'(sz) > (1 << AW)) ? (1 << AW) : int'(sz);
    preload(n + 4);
    h0 = head;
    @(negedge aclk);
    start = 1'b1; size = sz; base = bs; stall = 1'b0;
    pops = 0; writes = 0; prev_pop = 1'b0; c = 0;
    done_cycle = (n == 0) ? 1 : -1;
    bound = n * 8 + 40;
    @(posedge aclk);
    forever begin
      @(negedge aclk);
      c++;
      case (stall_mode)
        1:       stall = ($urandom_range(0, 3) == 0);
        2:       stall = (c >= 2 && c <= 4);
        default: stall = 1'b0;
      endcase
      if (toggle && pops < n) begin
        start = 1'($urandom);
        size  = (AW+1)'($urandom);
        base  = AW'($urandom);
      end else begin
        start = 1'b1;
      end
      #1;
      exp_done = (done_cycle >= 0) && (c >= done_cycle);
      exp_pop  = (pops < n) && !empty;
      checks++;
      if (rd !== exp_pop) $display("FAIL %s rd c%0d: got %b want %b", tag, c, rd, exp_pop);
      else passed++;
      checks++;
      if (done !== exp_done) $display("FAIL %s done c%0d: got %b want %b", tag, c, done, exp_done);
      else passed++;
      checks++;
      if (busy !== !exp_done) $display("FAIL %s busy c%0d: got %b want %b", tag, c, busy, !exp_done);
      else passed++;
      checks++;
      if (mem_we !== prev_pop || mem_en !== prev_pop)
        $display("FAIL %s strobe c%0d: got en=%b we=%b want %b", tag, c, mem_en, mem_we, prev_pop);
      else passed++;
      if (prev_pop) begin
        exp_addr = bs + AW'(writes);
        checks++;
        if (mem_addr !== exp_addr) $display("FAIL %s addr w%0d: got %h want %h", tag, writes, mem_addr, exp_addr);
        else passed++;
        checks++;
        if (mem_din !== fifo_mem[(h0 + writes) % FIFO_DEPTH])
          $display("FAIL %s data w%0d: got %h want %h", tag, writes, mem_din, fifo_mem[(h0 + writes) % FIFO_DEPTH]);
        else passed++;
        writes++;
      end
      if (exp_pop) begin
        pops++;
        if (pops == n) done_cycle = c + 2;
      end
      prev_pop = exp_pop;
      if (abort_after > 0 && writes == abort_after) begin
        areset = 1'b1;
        start  = 1'b0;
        #1;
        checks++;
        if ({rd, mem_en, mem_we, busy, done} !== 5'b0 || mem_addr !== '0 || mem_din !== '0)
          $display("FAIL %s async reset: got rd=%b en=%b we=%b busy=%b done=%b addr=%h din=%h want all 0",
                   tag, rd, mem_en, mem_we, busy, done, mem_addr, mem_din);
        else passed++;
        @(negedge aclk);
        areset = 1'b0;
        stall  = 1'b0;
        return;
      end
      if (exp_done && c >= done_cycle + 2) break;
      if (c > bound) begin
        checks++;
        $display("FAIL %s timeout: got done=%b after %0d cycles want done", tag, done, c);
        break;
      end
    end
    checks++;
    if (writes !== n) $display("FAIL %s write count: got %0d want %0d", tag, writes, n);
    else passed++;
    start = 1'b0;
    stall = 1'b0;
    @(negedge aclk);
    #1;
    checks++;
    if ({done, busy, rd, mem_we} !== 4'b0)
      $display("FAIL %s idle return: got done=%b busy=%b rd=%b we=%b want 0", tag, done, busy, rd, mem_we);
    else passed++;
  endtask

  task automatic test_reset();
    areset = 1'b1; start = 1'b0; size = '0; base = '0; stall = 1'b0;
    repeat (3) @(negedge aclk);
    #1;
    checks++;
    if ({rd, mem_en, mem_we, busy, done} !== 5'b0 || mem_addr !== '0 || mem_din !== '0)
      $display("FAIL reset values: got rd=%b en=%b we=%b busy=%b done=%b addr=%h din=%h want all 0",
               rd, mem_en, mem_we, busy, done, mem_addr, mem_din);
    else passed++;
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic test_basic_burst();
    run_transfer(13'd4, 12'h010, 0, 1'b0, 0, "basic");
  endtask

  task automatic test_fifo_stall();
    run_transfer(13'd3, AW'($urandom), 2, 1'b0, 0, "stall");
  endtask

  task automatic test_wrap_clamp();
    run_transfer(13'd3, 12'hFFE, 0, 1'b0, 0, "wrap");
    run_transfer(13'h1FFF, AW'($urandom), 0, 1'b0, 0, "clamp");
  endtask

  task automatic test_zero_size();
    run_transfer(13'd0, AW'($urandom), 0, 1'b0, 0, "zero");
  endtask

  task automatic test_reset_mid();
    run_transfer(13'd5, 12'h100, 0, 1'b0, 2, "abort");
    run_transfer(13'd1, 12'h3A5, 0, 1'b0, 0, "after_abort");
  endtask

  task automatic test_ignored_start();
    run_transfer(13'd6, AW'($urandom), 1, 1'b1, 0, "ignored_start");
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_transfer((AW+1)'($urandom_range(1, 40)), AW'($urandom), 1, 1'b0, 0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_fifo_stall();
    test_wrap_clamp();
    test_zero_size();
    test_reset_mid();
    test_ignored_start();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
